// File: rtl/lcd_pkg.sv
// Shared HD44780 bus definitions: op codes, reader states, 50 MHz timing, command bytes.
package lcd_pkg;

    typedef enum logic [1:0] {
        OP_READ_BF_AC = 2'd0,
        OP_READ_DATA  = 2'd1,
        OP_POLL_BF    = 2'd2,
        OP_RSVD       = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_EN_HIGH = 3'd2,
        ST_HOLD    = 3'd3,
        ST_GAP     = 3'd4,
        ST_RESP    = 3'd5
    } state_e;

    // Bus phase timing in 20 ns clk cycles.
    localparam int T_AS_CYC  = 3;    // RS/RW setup before E rises
    localparam int T_PW_CYC  = 13;   // E high, covers data-out delay
    localparam int T_H_CYC   = 2;    // RS/RW hold after E falls
    localparam int T_GAP_CYC = 15;   // E low between poll reads
    localparam logic [15:0] POLL_MAX_DEF = 16'd50000;

    // Command execution delays used by the write FSM.
    localparam int T_CMD_CYC   = 2000;   // 40 us typical command
    localparam int T_CLEAR_CYC = 82000;  // 1.64 ms clear/home

    // HD44780 command bytes.
    localparam logic [7:0] CMD_CLEAR      = 8'h01;
    localparam logic [7:0] CMD_HOME       = 8'h02;
    localparam logic [7:0] CMD_ENTRY_INC  = 8'h06;
    localparam logic [7:0] CMD_DISP_ON    = 8'h0C;
    localparam logic [7:0] CMD_FUNC_8B_2L = 8'h38;
    localparam logic [7:0] CMD_SET_CGRAM  = 8'h40;
    localparam logic [7:0] CMD_SET_DDRAM  = 8'h80;

    // Saturating 16-bit increment for the E-pulse counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter; done is high during the last cycle of a loaded phase.
module lcd_phase_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       done
);

    logic [7:0] cnt;

    // Load on phase entry, then count down to zero and stop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          cnt <= 8'd0;
        else if (load)       cnt <= load_val;
        else if (cnt != 8'd0) cnt <= cnt - 8'd1;
    end

    // Derived from the counter only, so done never depends on load (no comb loop).
    assign done = (cnt == 8'd1);

endmodule

// File: rtl/lcd_reader.sv
// Read-side master for the 8-bit HD44780 bus: BF/AC read, data read, busy poll.
module lcd_reader
    import lcd_pkg::*;
#(
    parameter int          T_AS     = T_AS_CYC,
    parameter int          T_PW     = T_PW_CYC,
    parameter int          T_H      = T_H_CYC,
    parameter int          T_GAP    = T_GAP_CYC,
    parameter logic [15:0] POLL_MAX = POLL_MAX_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [1:0]  req_op,
    output logic        req_ready,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_data,
    output logic        rsp_busy,
    output logic [6:0]  rsp_addr,
    output logic        rsp_err,
    output logic [15:0] rsp_reads,
    input  logic [7:0]  lcd_data_in,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_en,
    output logic        bus_own
);

    // Phase timer is 8 bits wide; every phase must fit in 1..255 cycles.
    if (T_AS < 1 || T_AS > 255 || T_PW < 1 || T_PW > 255 ||
        T_H < 1 || T_H > 255 || T_GAP < 1 || T_GAP > 255) begin : g_bad_timing
        $error("lcd_reader: phase length outside 1..255 cycles");
    end

    localparam logic [7:0] AS8  = 8'(T_AS);
    localparam logic [7:0] PW8  = 8'(T_PW);
    localparam logic [7:0] H8   = 8'(T_H);
    localparam logic [7:0] GAP8 = 8'(T_GAP);

    state_e     state, state_nxt;
    op_e        op_q, op_nxt;
    logic       accept, done, load, timeout;
    logic [7:0] load_val;
    logic       rs_nxt, rw_nxt, en_nxt, own_nxt, rdy_nxt, vld_nxt;

    assign accept  = (state == ST_IDLE) && req_valid && req_ready;
    assign op_nxt  = accept ? op_e'(req_op) : op_q;
    // BF still set after the POLL_MAX-th read: give up.
    assign timeout = (op_q == OP_POLL_BF) && rsp_data[7] && (rsp_reads >= POLL_MAX);
    assign load    = (state_nxt != state);

    lcd_phase_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (load_val),
        .done     (done)
    );

    // Phase length for the state being entered.
    always_comb begin
        load_val = 8'd0;
        case (state_nxt)
            ST_SETUP:   load_val = AS8;
            ST_EN_HIGH: load_val = PW8;
            ST_HOLD:    load_val = H8;
            ST_GAP:     load_val = GAP8;
            default:    load_val = 8'd0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            op_q  <= OP_READ_BF_AC;
        end else begin
            state <= state_nxt;
            op_q  <= op_nxt;
        end
    end

    // Next-state logic; phases advance on the timer's done.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (accept) state_nxt = (req_op == OP_RSVD) ? ST_RESP : ST_SETUP;
            ST_SETUP:   if (done) state_nxt = ST_EN_HIGH;
            ST_EN_HIGH: if (done) state_nxt = ST_HOLD;
            ST_HOLD:    if (done) state_nxt = (op_q != OP_POLL_BF || !rsp_data[7] || timeout)
                                              ? ST_RESP : ST_GAP;
            ST_GAP:     if (done) state_nxt = ST_SETUP;
            ST_RESP:    if (rsp_ready) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Bus/handshake values for the upcoming state; registered below.
    always_comb begin
        rs_nxt  = 1'b0;
        rw_nxt  = 1'b0;
        en_nxt  = 1'b0;
        own_nxt = 1'b0;
        rdy_nxt = 1'b0;
        vld_nxt = 1'b0;
        case (state_nxt)
            ST_IDLE: rdy_nxt = 1'b1;
            ST_SETUP, ST_EN_HIGH, ST_HOLD, ST_GAP: begin
                rs_nxt  = (op_nxt == OP_READ_DATA);
                rw_nxt  = 1'b1;
                own_nxt = 1'b1;
                en_nxt  = (state_nxt == ST_EN_HIGH);
            end
            ST_RESP: vld_nxt = 1'b1;
            default: ;
        endcase
    end

    // Registered outputs, capture register, pulse counter and response fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lcd_rs    <= 1'b0;
            lcd_rw    <= 1'b0;
            lcd_en    <= 1'b0;
            bus_own   <= 1'b0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= 8'h00;
            rsp_reads <= 16'd0;
            rsp_busy  <= 1'b0;
            rsp_addr  <= 7'd0;
            rsp_err   <= 1'b0;
        end else begin
            lcd_rs    <= rs_nxt;
            lcd_rw    <= rw_nxt;
            lcd_en    <= en_nxt;
            bus_own   <= own_nxt;
            req_ready <= rdy_nxt;
            rsp_valid <= vld_nxt;
            if (accept) begin
                rsp_data  <= 8'h00;
                rsp_reads <= 16'd0;
                rsp_busy  <= 1'b0;
                rsp_addr  <= 7'd0;
                rsp_err   <= 1'b0;
            end else begin
                if (state == ST_EN_HIGH && done) rsp_data <= lcd_data_in;
                if (state == ST_SETUP && done)   rsp_reads <= sat_inc16(rsp_reads);
            end
            // Decode only on RESP entry so fields stay frozen under backpressure.
            if (state == ST_HOLD && state_nxt == ST_RESP) begin
                rsp_err  <= timeout;
                rsp_busy <= (op_q != OP_READ_DATA) && rsp_data[7];
                rsp_addr <= (op_q != OP_READ_DATA) ? rsp_data[6:0] : 7'd0;
            end else if (state == ST_IDLE && state_nxt == ST_RESP) begin
                rsp_err  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lcd_reader.sv
// Self-checking bench for lcd_reader: directed scenarios plus randomized ops vs a timing model.
module tb_lcd_reader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] req_op = 2'd0;
    logic req_valid_a = 1'b0, req_valid_b = 1'b0;
    logic rsp_ready_a = 1'b1, rsp_ready_b = 1'b1;
    logic [7:0] data_a = 8'h00, data_b = 8'hFF;

    logic rdy_a, vld_a, busy_a, err_a, rs_a, rw_a, en_a, own_a;
    logic rdy_b, vld_b, busy_b, err_b, rs_b, rw_b, en_b, own_b;
    logic [7:0] rdata_a, rdata_b;
    logic [6:0] addr_a, addr_b;
    logic [15:0] reads_a, reads_b;

    int passed = 0, total = 0;

    always #10 clk = ~clk;

    lcd_reader dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_a), .req_op(req_op), .req_ready(rdy_a),
        .rsp_valid(vld_a), .rsp_ready(rsp_ready_a), .rsp_data(rdata_a), .rsp_busy(busy_a),
        .rsp_addr(addr_a), .rsp_err(err_a), .rsp_reads(reads_a), .lcd_data_in(data_a),
        .lcd_rs(rs_a), .lcd_rw(rw_a), .lcd_en(en_a), .bus_own(own_a)
    );

    lcd_reader #(.POLL_MAX(16'd4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_b), .req_op(req_op), .req_ready(rdy_b),
        .rsp_valid(vld_b), .rsp_ready(rsp_ready_b), .rsp_data(rdata_b), .rsp_busy(busy_b),
        .rsp_addr(addr_b), .rsp_err(err_b), .rsp_reads(reads_b), .lcd_data_in(data_b),
        .lcd_rs(rs_b), .lcd_rw(rw_b), .lcd_en(en_b), .bus_own(own_b)
    );

    // Panel model: each E rising edge presents the next byte of panel_vals.
    logic [7:0] panel_vals [0:7];
    int pcount = 0, base = 0, pidx;
    always @(posedge en_a) begin
        pidx = pcount - base;
        if (pidx > 7) pidx = 7;
        if (pidx < 0) pidx = 0;
        data_a = panel_vals[pidx];
        pcount++;
    end

    // Trace results (cycle 1 = sample just after the accept edge).
    int t_vcyc, t_pulses, t_wmin, t_wmax, t_gapmin, t_first;
    logic t_rw1, t_rs1, s_busy, s_err;
    logic [7:0] s_data;
    logic [6:0] s_addr;
    logic [15:0] s_reads;

    task automatic wait_idle(input bit sel);
        int i = 0;
        while (i < 50 && !(sel ? rdy_b : rdy_a)) begin @(posedge clk); #1; i++; end
        total++;
        if (!(sel ? rdy_b : rdy_a)) $display("FAIL wait_idle: req_ready stayed 0 after %0d cycles", i);
        else passed++;
    endtask

    task automatic issue(input bit sel, input logic [1:0] op);
        wait_idle(sel);
        base = pcount;
        req_op = op;
        if (sel) req_valid_b = 1'b1; else req_valid_a = 1'b1;
        @(posedge clk); #1;
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
    endtask

    task automatic run(input bit sel, input int budget);
        int w = 0, lo = 0;
        bit pe = 1'b0, en;
        t_vcyc = 0; t_pulses = 0; t_wmin = 999; t_wmax = 0; t_gapmin = 999; t_first = 0;
        t_rw1 = sel ? rw_b : rw_a;
        t_rs1 = sel ? rs_b : rs_a;
        for (int c = 1; c <= budget; c++) begin
            en = sel ? en_b : en_a;
            if (en && !pe) begin
                t_pulses++;
                if (t_pulses == 1) t_first = c;
                else if (lo < t_gapmin) t_gapmin = lo;
                w = 0;
            end
            if (en) w++;
            if (!en && pe) begin
                if (w < t_wmin) t_wmin = w;
                if (w > t_wmax) t_wmax = w;
                lo = 0;
            end
            if (!en) lo++;
            pe = en;
            if (sel ? vld_b : vld_a) begin
                t_vcyc  = c;
                s_data  = sel ? rdata_b : rdata_a;
                s_busy  = sel ? busy_b : busy_a;
                s_addr  = sel ? addr_b : addr_a;
                s_err   = sel ? err_b : err_a;
                s_reads = sel ? reads_b : reads_a;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        #25;
        total++;
        if ({rdy_a, vld_a, rdata_a, busy_a, addr_a, err_a, reads_a, rs_a, rw_a, en_a, own_a} !== '0)
            $display("FAIL reset_outputs: got rdy=%b vld=%b data=%h rw=%b en=%b own=%b want all 0",
                     rdy_a, vld_a, rdata_a, rw_a, en_a, own_a);
        else passed++;
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (rdy_a !== 1'b1 || rdy_b !== 1'b1) $display("FAIL reset_ready: got %b/%b want 1/1", rdy_a, rdy_b);
        else passed++;
    endtask

    task automatic test_read_data();
        panel_vals[0] = 8'h41;
        issue(0, 2'd1);
        run(0, 100);
        total++; if (t_rs1 !== 1'b1 || t_rw1 !== 1'b1) $display("FAIL rd_rs_rw_c1: got rs=%b rw=%b want 1/1", t_rs1, t_rw1); else passed++;
        total++; if (t_first != 4 || t_wmax != 13 || t_wmin != 13 || t_pulses != 1)
            $display("FAIL rd_en_pulse: got first=%0d w=%0d/%0d n=%0d want 4 13 13 1", t_first, t_wmin, t_wmax, t_pulses); else passed++;
        total++; if (t_vcyc != 19) $display("FAIL rd_latency: got %0d want 19", t_vcyc); else passed++;
        total++; if ({s_data, s_busy, s_addr, s_reads, s_err} !== {8'h41, 1'b0, 7'd0, 16'd1, 1'b0})
            $display("FAIL rd_fields: got data=%h busy=%b addr=%h reads=%0d err=%b want 41 0 00 1 0",
                     s_data, s_busy, s_addr, s_reads, s_err); else passed++;
    endtask

    task automatic test_read_bf();
        panel_vals[0] = 8'h85;
        issue(0, 2'd0);
        run(0, 100);
        total++; if (t_rs1 !== 1'b0 || t_rw1 !== 1'b1) $display("FAIL bf_rs_rw_c1: got rs=%b rw=%b want 0/1", t_rs1, t_rw1); else passed++;
        total++; if (t_vcyc != 19) $display("FAIL bf_latency: got %0d want 19", t_vcyc); else passed++;
        total++; if ({s_data, s_busy, s_addr, s_reads} !== {8'h85, 1'b1, 7'h05, 16'd1})
            $display("FAIL bf_fields: got data=%h busy=%b addr=%h reads=%0d want 85 1 05 1",
                     s_data, s_busy, s_addr, s_reads); else passed++;
    endtask

    task automatic test_poll();
        panel_vals[0] = 8'h80; panel_vals[1] = 8'h80; panel_vals[2] = 8'h80; panel_vals[3] = 8'h12;
        issue(0, 2'd2);
        run(0, 400);
        total++; if (t_pulses != 4 || t_wmin != 13 || t_wmax != 13)
            $display("FAIL poll_pulses: got n=%0d w=%0d/%0d want 4 13 13", t_pulses, t_wmin, t_wmax); else passed++;
        total++; if (t_gapmin < 17) $display("FAIL poll_gap: got %0d want >=17", t_gapmin); else passed++;
        total++; if (t_vcyc != 118) $display("FAIL poll_latency: got %0d want 118", t_vcyc); else passed++;
        total++; if ({s_busy, s_addr, s_reads, s_err} !== {1'b0, 7'h12, 16'd4, 1'b0})
            $display("FAIL poll_fields: got busy=%b addr=%h reads=%0d err=%b want 0 12 4 0",
                     s_busy, s_addr, s_reads, s_err); else passed++;
    endtask

    task automatic test_poll_timeout();
        issue(1, 2'd2);
        run(1, 400);
        total++; if (t_pulses != 4) $display("FAIL tmo_pulses: got %0d want 4", t_pulses); else passed++;
        total++; if (t_vcyc != 118) $display("FAIL tmo_latency: got %0d want 118", t_vcyc); else passed++;
        total++; if ({s_err, s_reads, s_busy} !== {1'b1, 16'd4, 1'b1})
            $display("FAIL tmo_fields: got err=%b reads=%0d busy=%b want 1 4 1", s_err, s_reads, s_busy); else passed++;
    endtask

    task automatic test_backpressure();
        bit stab = 1'b1, en_seen = 1'b0, rr_seen = 1'b0;
        panel_vals[0] = 8'hDA;
        wait_idle(0);
        base = pcount;
        rsp_ready_a = 1'b0;
        req_op = 2'd0;
        req_valid_a = 1'b1;
        @(posedge clk); #1;
        run(0, 100);
        total++; if (t_vcyc != 19 || s_data !== 8'hDA) $display("FAIL bp_first: got cyc=%0d data=%h want 19 da", t_vcyc, s_data); else passed++;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if ({vld_a, rdata_a, busy_a, addr_a, err_a, reads_a} !== {1'b1, s_data, s_busy, s_addr, s_err, s_reads}) stab = 1'b0;
            en_seen |= en_a;
            rr_seen |= rdy_a;
        end
        total++; if (stab !== 1'b1) $display("FAIL bp_stable: rsp fields changed while held, got 0 want 1"); else passed++;
        total++; if ({en_seen, rr_seen} !== 2'b00) $display("FAIL bp_quiet: got en_seen=%b req_ready_seen=%b want 0 0", en_seen, rr_seen); else passed++;
        rsp_ready_a = 1'b1;
        @(posedge clk); #1;
        total++; if ({vld_a, rdy_a, rw_a} !== 3'b010) $display("FAIL bp_release: got vld=%b rdy=%b rw=%b want 0 1 0", vld_a, rdy_a, rw_a); else passed++;
        base = pcount;
        @(posedge clk); #1;
        req_valid_a = 1'b0;
        total++; if ({rw_a, rdy_a} !== 2'b10) $display("FAIL bp_reaccept: got rw=%b rdy=%b want 1 0", rw_a, rdy_a); else passed++;
        run(0, 100);
        total++; if (t_vcyc != 19 || s_data !== 8'hDA) $display("FAIL bp_second: got cyc=%0d data=%h want 19 da", t_vcyc, s_data); else passed++;
    endtask

    task automatic test_reset_mid_and_rsvd();
        panel_vals[0] = 8'h77;
        issue(0, 2'd1);
        for (int i = 0; i < 7; i++) begin @(posedge clk); #1; end
        total++; if (en_a !== 1'b1) $display("FAIL mid_en_before: got %b want 1", en_a); else passed++;
        #4 rst_n = 1'b0;
        #1;
        total++; if ({en_a, rw_a, own_a} !== 3'b000) $display("FAIL mid_reset_drop: got en=%b rw=%b own=%b want 0 0 0", en_a, rw_a, own_a); else passed++;
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        panel_vals[0] = 8'h20;
        issue(0, 2'd1);
        run(0, 100);
        total++; if (t_vcyc != 19 || s_data !== 8'h20 || s_reads !== 16'd1)
            $display("FAIL post_reset_read: got cyc=%0d data=%h reads=%0d want 19 20 1", t_vcyc, s_data, s_reads); else passed++;
        issue(0, 2'd3);
        run(0, 10);
        total++; if (t_vcyc != 1 || t_pulses != 0) $display("FAIL rsvd_timing: got cyc=%0d pulses=%0d want 1 0", t_vcyc, t_pulses); else passed++;
        total++; if ({s_err, s_reads, s_data} !== {1'b1, 16'd0, 8'h00})
            $display("FAIL rsvd_fields: got err=%b reads=%0d data=%h want 1 0 00", s_err, s_reads, s_data); else passed++;
    endtask

    task automatic test_random();
        logic [1:0] op;
        int k, n, e_vcyc;
        logic [7:0] e_data;
        logic e_busy;
        logic [6:0] e_addr;
        for (int it = 0; it < 10; it++) begin
            op = 2'($urandom_range(0, 2));
            k  = (op == 2'd2) ? int'($urandom_range(0, 3)) : 0;
            for (int j = 0; j < k; j++) panel_vals[j] = 8'h80 | 8'($urandom_range(0, 127));
            panel_vals[k] = (op == 2'd2) ? 8'($urandom_range(0, 127)) : 8'($urandom_range(0, 255));
            // Reference: one E pulse per read, poll stops at first BF=0, 33 cycles per extra read.
            n      = k + 1;
            e_data = panel_vals[k];
            e_busy = (op != 2'd1) && e_data[7];
            e_addr = (op != 2'd1) ? e_data[6:0] : 7'd0;
            e_vcyc = 19 + 33 * (n - 1);
            issue(0, op);
            run(0, 400);
            total++;
            if (t_vcyc != e_vcyc || t_pulses != n || s_data !== e_data || s_busy !== e_busy ||
                s_addr !== e_addr || s_err !== 1'b0 || s_reads !== 16'(n))
                $display("FAIL rand_%0d op%0d: got cyc=%0d n=%0d data=%h busy=%b addr=%h err=%b reads=%0d want cyc=%0d n=%0d data=%h busy=%b addr=%h err=0 reads=%0d",
                         it, op, t_vcyc, t_pulses, s_data, s_busy, s_addr, s_err, s_reads,
                         e_vcyc, n, e_data, e_busy, e_addr, n);
            else passed++;
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) panel_vals[i] = 8'h00;
        test_reset();
        test_read_data();
        test_read_bf();
        test_poll();
        test_poll_timeout();
        test_backpressure();
        test_reset_mid_and_rsvd();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
